// File: rtl/tiger_defs.sv
// tiger_defs: shared state encoding and defaults for the tiger memory arbiter.
package tiger_defs;

    localparam int ADDR_W_DEFAULT = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_I_REQ   = 3'd1;
    localparam logic [2:0] ST_I_WAIT  = 3'd2;
    localparam logic [2:0] ST_D_REQ   = 3'd3;
    localparam logic [2:0] ST_D_WAIT  = 3'd4;
    localparam logic [2:0] ST_D_WRITE = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        I_REQ   = ST_I_REQ,
        I_WAIT  = ST_I_WAIT,
        D_REQ   = ST_D_REQ,
        D_WAIT  = ST_D_WAIT,
        D_WRITE = ST_D_WRITE
    } state_t;

    function automatic logic is_data(state_t s);
        return s inside {D_REQ, D_WAIT, D_WRITE};
    endfunction

endpackage

// File: rtl/tiger_sat_counter.sv
// tiger_sat_counter: event counter that sticks at all-ones instead of wrapping.
module tiger_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign count_o = cnt_q;

endmodule

// File: rtl/tiger_mem_arbiter.sv
// tiger_mem_arbiter: shares one memory port between instruction and data caches,
// one transaction in flight, fair alternation unless a checkpoint forces data priority.
module tiger_mem_arbiter
    import tiger_defs::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [31:0]       i_readdata,
    output logic              i_waitrequest,
    output logic              i_readdatavalid,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [31:0]       d_writedata,
    input  logic [3:0]        d_byteenable,
    output logic [31:0]       d_readdata,
    output logic              d_waitrequest,
    output logic              d_readdatavalid,
    input  logic              checkpointing,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest,
    input  logic              m_readdatavalid,
    output logic [15:0]       conflict_count
);

    state_t state_q;
    logic   last_d_q, m_read_q, m_write_q;
    logic   d_req, grant_d, data_sel;

    assign d_req   = d_read | d_write;
    // last_d_q low means instruction was served last, so data wins a tie
    assign grant_d = d_req && (checkpointing || !i_read || !last_d_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q   <= d_write ? D_WRITE : D_REQ;
                        last_d_q  <= 1'b1;
                        m_read_q  <= !d_write;
                        m_write_q <= d_write;
                    end else if (i_read) begin
                        state_q  <= I_REQ;
                        last_d_q <= 1'b0;
                        m_read_q <= 1'b1;
                    end
                end
                I_REQ: if (!m_waitrequest) begin
                    state_q  <= I_WAIT;
                    m_read_q <= 1'b0;
                end
                D_REQ: if (!m_waitrequest) begin
                    state_q  <= D_WAIT;
                    m_read_q <= 1'b0;
                end
                D_WRITE: if (!m_waitrequest) begin
                    state_q   <= IDLE;
                    m_write_q <= 1'b0;
                end
                I_WAIT, D_WAIT: if (m_readdatavalid) state_q <= IDLE;
                default: begin
                    state_q   <= IDLE;
                    m_read_q  <= 1'b0;
                    m_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_sel     = is_data(state_q);
    assign m_read       = m_read_q;
    assign m_write      = m_write_q;
    assign m_address    = data_sel ? d_address : i_address;
    assign m_writedata  = d_writedata;
    assign m_byteenable = data_sel ? d_byteenable : 4'hF;

    assign i_waitrequest = (state_q == I_REQ) ? m_waitrequest : i_read;
    assign d_waitrequest = (state_q == D_REQ || state_q == D_WRITE) ? m_waitrequest : d_req;

    assign i_readdata      = m_readdata;
    assign d_readdata      = m_readdata;
    assign i_readdatavalid = (state_q == I_WAIT) && m_readdatavalid;
    assign d_readdatavalid = (state_q == D_WAIT) && m_readdatavalid;

    tiger_sat_counter #(.W(16)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (state_q == IDLE && i_read && d_req),
        .count_o (conflict_count)
    );

endmodule

// File: tb/tb_tiger_mem_arbiter.sv
// tb_tiger_mem_arbiter: randomized traffic against a transaction-level model of the arbiter.
module tb_tiger_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_address = '0;
    logic [31:0] i_readdata;
    logic        i_waitrequest, i_readdatavalid;
    logic        d_read = 1'b0, d_write = 1'b0;
    logic [31:0] d_address = '0, d_writedata = '0;
    logic [3:0]  d_byteenable = '0;
    logic [31:0] d_readdata;
    logic        d_waitrequest, d_readdatavalid;
    logic        checkpointing = 1'b0;
    logic        m_read, m_write;
    logic [31:0] m_address, m_writedata;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
    logic [15:0] conflict_count;

    tiger_mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
        .i_waitrequest(i_waitrequest), .i_readdatavalid(i_readdatavalid),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable), .d_readdata(d_readdata),
        .d_waitrequest(d_waitrequest), .d_readdatavalid(d_readdatavalid),
        .checkpointing(checkpointing),
        .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
        .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int p_i, p_d, p_ck, p_wt, p_rv;
    // model: one transaction in flight, who owns it, whether the slave has taken it
    logic busy, own_d, is_wr, acc, last_d;
    int   cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 0; own_d = 0; is_wr = 0; acc = 0; last_d = 0; cnt = 0;
    endtask

    task automatic step();
        logic e_mr, e_mw, e_iw, e_dw, i_acc, d_acc, dreq;
        @(negedge clk);
        dreq = d_read | d_write;
        e_mr = busy && !acc && !is_wr;
        e_mw = busy && !acc && is_wr;
        e_iw = (busy && !own_d && !acc) ? m_waitrequest : i_read;
        e_dw = (busy && own_d && !acc) ? m_waitrequest : dreq;
        check("m_read", m_read, e_mr);
        check("m_write", m_write, e_mw);
        if (e_mr || e_mw) begin
            check("m_address", m_address, own_d ? d_address : i_address);
            check("m_byteenable", m_byteenable, own_d ? d_byteenable : 4'hF);
        end
        if (e_mw) check("m_writedata", m_writedata, d_writedata);
        check("i_waitrequest", i_waitrequest, e_iw);
        check("d_waitrequest", d_waitrequest, e_dw);
        check("i_readdatavalid", i_readdatavalid, busy && !own_d && acc && m_readdatavalid);
        check("d_readdatavalid", d_readdatavalid, busy && own_d && acc && m_readdatavalid);
        check("i_readdata", i_readdata, m_readdata);
        check("d_readdata", d_readdata, m_readdata);
        check("conflict_count", conflict_count, cnt);
        i_acc = i_read && !e_iw;
        d_acc = dreq && !e_dw;
        if (!busy) begin
            if (i_read && dreq && cnt < 65535) cnt++;
            if (dreq && (checkpointing || !i_read || !last_d)) begin
                busy = 1; own_d = 1; is_wr = d_write; acc = 0; last_d = 1;
            end else if (i_read) begin
                busy = 1; own_d = 0; is_wr = 0; acc = 0; last_d = 0;
            end
        end else if (!acc) begin
            if (!m_waitrequest) begin
                if (is_wr) busy = 0;
                else acc = 1;
            end
        end else if (m_readdatavalid) busy = 0;
        @(posedge clk);
        #1;
        if (i_acc) i_read = 1'b0;
        if (!i_read && $urandom_range(99) < p_i) begin
            i_read = 1'b1;
            i_address = $urandom;
        end
        if (d_acc) begin
            d_read = 1'b0;
            d_write = 1'b0;
        end
        if (!(d_read | d_write) && $urandom_range(99) < p_d) begin
            case ($urandom_range(3))
                0, 1: d_read = 1'b1;
                2: d_write = 1'b1;
                default: begin d_read = 1'b1; d_write = 1'b1; end
            endcase
            d_address = $urandom;
            d_writedata = $urandom;
            d_byteenable = 4'($urandom);
        end
        checkpointing = $urandom_range(99) < p_ck;
        m_waitrequest = $urandom_range(99) < p_wt;
        m_readdatavalid = $urandom_range(99) < p_rv;
        m_readdata = $urandom;
    endtask

    task automatic run(input int n, input int pi, input int pd, input int pck, input int pwt, input int prv);
        p_i = pi; p_d = pd; p_ck = pck; p_wt = pwt; p_rv = prv;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        model_reset();
        #8;
        check("rst_m_read", m_read, 0);
        check("rst_m_write", m_write, 0);
        check("rst_i_rdv", i_readdatavalid, 0);
        check("rst_d_rdv", d_readdatavalid, 0);
        check("rst_count", conflict_count, 0);
        #14 reset_n = 1'b1;
        // contention from the first cycle: data first, then strict alternation
        run(200, 100, 100, 0, 0, 50);
        run(3000, 40, 40, 20, 40, 40);
        // checkpoint: data monopolises the port
        run(200, 100, 100, 100, 30, 50);
        // reach I_WAIT, then drop reset while the read is outstanding
        run(20, 0, 0, 0, 0, 100);
        p_i = 100; p_d = 0; p_ck = 0; p_wt = 0; p_rv = 0;
        for (int k = 0; k < 60 && !(busy && acc && !own_d); k++) step();
        check("reach_i_wait", {31'd0, busy && acc && !own_d}, 1);
        reset_n = 1'b0;
        m_readdatavalid = 1'b1;
        i_read = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        #1;
        check("async_rst_i_rdv", i_readdatavalid, 0);
        check("async_rst_m_read", m_read, 0);
        check("async_rst_count", conflict_count, 0);
        model_reset();
        @(negedge clk);
        #2 reset_n = 1'b1;
        run(6, 0, 0, 0, 0, 100);
        run(60, 100, 100, 0, 0, 50);
        // jump the counter near its ceiling, then keep contending
        force dut.u_cnt.cnt_q = 16'hFFF0;
        #1 release dut.u_cnt.cnt_q;
        cnt = 65520;
        run(300, 100, 100, 30, 0, 60);
        check("count_saturated", conflict_count, 16'hFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tiger_mem_arbiter.md
TIGER_MEM_ARBITER -- requirements
Module: tiger_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Ports (clock and reset first):
 clk  in  1  single clock; all state on rising edge
 reset_n  in  1  asynchronous, active-low reset
 i_read  in  1  instruction-cache read request
 i_address  in  ADDR_W  instruction read address
 i_readdata  out  32  instruction read data
 i_waitrequest  out  1  stall to instruction cache
 i_readdatavalid  out  1  instruction read data valid
 d_read  in  1  data-cache read request
 d_write  in  1  data-cache write request
 d_address  in  ADDR_W  data address
 d_writedata  in  32  data write data
 d_byteenable  in  4  data byte enables
 d_readdata  out  32  data read data
 d_waitrequest  out  1  stall to data cache
 d_readdatavalid  out  1  data read data valid
 checkpointing  in  1  checkpoint write-back active; data master gets absolute priority
 m_read  out  1  shared-port read
 m_write  out  1  shared-port write
 m_address  out  ADDR_W  shared-port address
 m_writedata  out  32  shared-port write data
 m_byteenable  out  4  shared-port byte enables (4'hF on instruction reads)
 m_readdata  in  32  shared-port read data
 m_waitrequest  in  1  shared-port stall
 m_readdatavalid  in  1  shared-port read data valid
 conflict_count  out  16  saturating count of contended arbitration cycles

Function
REQ-003 The FSM SHALL have states IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT, D_WRITE; exactly one transaction outstanding at any time.
REQ-004 In IDLE, arbitration SHALL be registered: a request sampled in cycle N drives m_read/m_write in cycle N+1.
REQ-005 Arbitration: checkpointing=1 -> data wins; else single requester wins; both requesting -> master not served last wins (last_served flag).
REQ-006 d_write with d_read both high SHALL be treated as a write.
REQ-007 I_REQ/D_REQ: m_read=1 with granted master's address; on m_waitrequest=0 -> I_WAIT/D_WAIT.
REQ-008 I_WAIT/D_WAIT: on m_readdatavalid=1 pulse owner's readdatavalid same cycle, -> IDLE.
REQ-009 D_WRITE: m_write=1 with d_address/d_writedata/d_byteenable; on m_waitrequest=0 -> IDLE.
REQ-010 m_address/m_writedata/m_byteenable SHALL be a combinational mux of the granted master's inputs; masters hold them stable while stalled.
REQ-011 Granted master's waitrequest SHALL equal m_waitrequest in *_REQ/D_WRITE; otherwise waitrequest=1 for any master asserting a request, 0 when not requesting.
REQ-012 i_readdata and d_readdata SHALL both carry m_readdata; readdatavalid asserted only to owner and only in its WAIT state; m_readdatavalid in any other state ignored.
REQ-013 last_served SHALL update on grant (entry to I_REQ -> instruction; D_REQ/D_WRITE -> data).
REQ-014 conflict_count SHALL increment by 1 each IDLE cycle with instruction and data both requesting, saturating at 16'hFFFF.
REQ-015 Shared port read response latency is >=1 cycle after acceptance; block adds zero latency on response path.

Reset
REQ-016 reset_n=0 SHALL asynchronously force IDLE, last_served=instruction, conflict_count=0, m_read=m_write=0, readdatavalid outputs 0.
REQ-017 Reset mid-transaction SHALL abandon it; stale m_readdatavalid after release is ignored per REQ-012.

Structure
REQ-018 State encoding localparams and ADDR_W default SHALL live in shared package tiger_defs.
REQ-019 Single module; no sub-module required (optional: tiger_sat_counter for REQ-014).

Verification
REQ-020 Idle, i_read=1 addr 0x100, slave waitrequest 2 cycles, readdatavalid 3 cycles later data 0xDEADBEEF -> m_read at cycle 1, i_readdatavalid one cycle with 0xDEADBEEF, d_readdatavalid never.
REQ-021 i_read and d_write same cycle after reset -> data granted first, instruction next; conflict_count=1.
REQ-022 Both masters requesting continuously, zero-wait slave -> grants alternate D,I,D,I; conflict_count increments per IDLE.
REQ-023 checkpointing=1, both requesting for 4 transactions -> all 4 granted to data; i_waitrequest stays 1.
REQ-024 reset_n low during I_WAIT, release, then spurious m_readdatavalid -> no readdatavalid output, state IDLE, counter 0.
REQ-025 Force 70000 contended cycles -> conflict_count holds 16'hFFFF.
